// File: rtl/systolic_row_feeder_pkg.sv
// Shared definitions for the systolic row feeder.
//  PE_DW   : default signed data width of weights and features (PE in_a width)
//  state_t : controller states IDLE -> W_FILL -> W_SHIFT -> F_STREAM -> DRAIN
//  SRF_LANE: selects lane r of a ROWS*DW bus, i.e. bus[r*DW +: DW]; uses the
//            DW parameter visible at the point of use.
package systolic_row_feeder_pkg;

   localparam int PE_DW = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_W_FILL   = 3'd1,
      ST_W_SHIFT  = 3'd2,
      ST_F_STREAM = 3'd3,
      ST_DRAIN    = 3'd4
   } state_t;

endpackage

`ifndef SRF_LANE
`define SRF_LANE(bus, r) bus[(r)*DW +: DW]
`endif

// File: rtl/systolic_row_feeder_skew_line.sv
// DEPTH-stage {enable, data} delay line used to skew one feature row.
// Ports:
//  clk, rst  : clock, synchronous active-high reset (clears every stage)
//  in_en     : enable entering the line this cycle
//  in_data   : feature entering the line this cycle
//  out_en    : in_en delayed DEPTH cycles
//  out_data  : in_data delayed DEPTH cycles
// Row 0 needs no delay and is wired directly in the top, so DEPTH >= 1 here.
module systolic_row_feeder_skew_line
   import systolic_row_feeder_pkg::*;
#(
   parameter int DEPTH = 1,
   parameter int DW    = PE_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_en,
   input  logic signed [DW-1:0] in_data,
   output logic                 out_en,
   output logic signed [DW-1:0] out_data
);

   logic [DEPTH-1:0]     en_q, en_d;
   logic signed [DW-1:0] data_q [DEPTH];
   logic signed [DW-1:0] data_d [DEPTH];

   always_comb begin
      en_d      = en_q;
      data_d    = data_q;
      en_d[0]   = in_en;
      data_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         en_d[i]   = en_q[i-1];
         data_d[i] = data_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q <= '0;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
         en_q   <= en_d;
         data_q <= data_d;
      end
   end

   assign out_en   = en_q[DEPTH-1];
   assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/systolic_row_feeder.sv
// Left-edge driver of a ROWS x COLS weight-stationary PE array.
// Buffers one weight tile (COLS beats, one column per beat), shifts it into
// the array last column first and issues one broadcast save, then streams
// feature vectors with row r delayed r cycles so partial sums line up down
// each column.
// Ports:
//  clk, rst          : clock, synchronous active-high reset
//  start, num_vec    : begin a job of num_vec vectors (sampled in IDLE only)
//  w_valid/w_ready   : weight beat handshake, w_data lane r = row r weight
//  f_valid/f_ready   : feature handshake, f_data lane r = row r feature
//  row_a, row_enable : registered in_a / enable into PE(r,0)
//  save              : registered broadcast weight-latch strobe
//  busy              : controller not in IDLE
//  done              : one-cycle pulse at job completion
// Requires ROWS >= 2 (DRAIN lasts ROWS-1 cycles).
module systolic_row_feeder
   import systolic_row_feeder_pkg::*;
#(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int DW   = PE_DW,
   parameter int CNTW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNTW-1:0]      num_vec,
   input  logic                 w_valid,
   output logic                 w_ready,
   input  logic [ROWS*DW-1:0]   w_data,
   input  logic                 f_valid,
   output logic                 f_ready,
   input  logic [ROWS*DW-1:0]   f_data,
   output logic [ROWS*DW-1:0]   row_a,
   output logic [ROWS-1:0]      row_enable,
   output logic                 save,
   output logic                 busy,
   output logic                 done
);

   localparam int MAXRC = (COLS > ROWS) ? COLS : ROWS;
   localparam int IDXW  = $clog2(MAXRC) + 1;

   state_t             state_q, state_d;
   logic [IDXW-1:0]    idx_q, idx_d;
   logic [CNTW-1:0]    vec_cnt_q, vec_cnt_d;
   logic [CNTW-1:0]    num_q, num_d;
   logic [ROWS*DW-1:0] wbuf_q [COLS];
   logic [ROWS*DW-1:0] wbuf_d [COLS];
   logic [ROWS*DW-1:0] row_a_q, row_a_d;
   logic [ROWS-1:0]    row_en_q, row_en_d;
   logic               save_q, save_d;
   logic               done_q, done_d;

   logic               w_acc, f_acc;
   logic [ROWS*DW-1:0] sk_out_data;
   logic [ROWS-1:0]    sk_out_en;

   assign w_ready = (state_q == ST_W_FILL);
   assign f_ready = (state_q == ST_F_STREAM);
   assign w_acc   = w_valid && w_ready;
   assign f_acc   = f_valid && f_ready;

   // Skew lines: a cycle without an accepted vector enters as a zero bubble.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic signed [DW-1:0] lane_in;
      assign lane_in = f_acc ? `SRF_LANE(f_data, r) : '0;
      if (r == 0) begin : g_direct
         assign `SRF_LANE(sk_out_data, r) = lane_in;
         assign sk_out_en[r]              = f_acc;
      end else begin : g_skew
         logic signed [DW-1:0] lane_out;
         systolic_row_feeder_skew_line #(.DEPTH(r), .DW(DW)) u_skew (
            .clk      (clk),
            .rst      (rst),
            .in_en    (f_acc),
            .in_data  (lane_in),
            .out_en   (sk_out_en[r]),
            .out_data (lane_out)
         );
         assign `SRF_LANE(sk_out_data, r) = lane_out;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      vec_cnt_d = vec_cnt_q;
      num_d     = num_q;
      wbuf_d    = wbuf_q;
      save_d    = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               num_d     = num_vec;
               idx_d     = '0;
               vec_cnt_d = '0;
               state_d   = ST_W_FILL;
            end
         end
         ST_W_FILL: begin
            if (w_acc) begin
               for (int k = 0; k < COLS; k++) begin
                  if (idx_q == IDXW'(k)) wbuf_d[k] = w_data;
               end
               if (idx_q == IDXW'(COLS-1)) begin
                  idx_d   = '0;
                  state_d = ST_W_SHIFT;
               end else begin
                  idx_d = idx_q + IDXW'(1);
               end
            end
         end
         ST_W_SHIFT: begin
            // Last shift cycle: column c now holds wbuf[c], so latch everywhere.
            if (idx_q == IDXW'(COLS-1)) begin
               save_d  = 1'b1;
               idx_d   = '0;
               state_d = (num_q == '0) ? ST_DRAIN : ST_F_STREAM;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         ST_F_STREAM: begin
            // num_q >= 1 here, so num_q-1 never wraps; vec_cnt tops out at num_q-1.
            if (f_acc) begin
               vec_cnt_d = vec_cnt_q + CNTW'(1);
               if (vec_cnt_q == num_q - CNTW'(1)) begin
                  idx_d   = '0;
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (idx_q == IDXW'(ROWS-2)) begin
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // W_SHIFT emits the tile last column first; every other state forwards the skew lines.
   always_comb begin
      row_a_d  = sk_out_data;
      row_en_d = sk_out_en;
      if (state_q == ST_W_SHIFT) begin
         row_en_d = '0;
         for (int k = 0; k < COLS; k++) begin
            if (idx_q == IDXW'(COLS-1-k)) row_a_d = wbuf_q[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         vec_cnt_q <= '0;
         num_q     <= '0;
         for (int k = 0; k < COLS; k++) wbuf_q[k] <= '0;
         row_a_q   <= '0;
         row_en_q  <= '0;
         save_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         vec_cnt_q <= vec_cnt_d;
         num_q     <= num_d;
         wbuf_q    <= wbuf_d;
         row_a_q   <= row_a_d;
         row_en_q  <= row_en_d;
         save_q    <= save_d;
         done_q    <= done_d;
      end
   end

   assign row_a      = row_a_q;
   assign row_enable = row_en_q;
   assign save       = save_q;
   assign done       = done_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
